motor_dir_sequencer: RTL

Command sequencer for the motor PWM/H-bridge datapath. It accepts direction and duty commands, ramps `pulse_width` toward the target duty, and makes every direction reversal safe: ramp to 0, hold a bridge-off dead time, flip the direction pins, then ramp up. An overcurrent fault input latches a shutdown state that only a clear input releases. It drives the existing PWM comparator (`pulse_width`) and the L298 direction pins for both motors.

---
 rtl/motor_dir_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/motor_dir_sequencer.sv
// Direction/duty command sequencer for the motor H-bridge: ramps pulse_width toward
// the commanded duty, inserts a bridge-off dead time on every reversal, and latches overcurrent.
module motor_dir_sequencer #(
  parameter int PW_W        = 19,
  parameter int PERIOD      = 250000,
  parameter int RAMP_STEP   = 2500,
  parameter int RAMP_TICKS  = 100000,
  parameter int DEAD_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  input  logic            cmd_dir,
  input  logic [PW_W-1:0] cmd_duty,
  output logic            cmd_ready,
  input  logic            oc_fault,
  input  logic            fault_clr,
  output logic [PW_W-1:0] pulse_width,
  output logic            in1_a,
  output logic            in2_a,
  output logic            in1_b,
  output logic            in2_b,
  output logic            cur_dir,
  output logic            busy,
  output logic [1:0]      state
);

  localparam int TW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PW_W-1:0] FULL      = PW_W'(PERIOD);
  localparam logic [PW_W-1:0] STEP      = PW_W'(RAMP_STEP);
  localparam logic [TW-1:0]   TICK_LAST = TW'(RAMP_TICKS - 1);
  localparam logic [DW-1:0]   DEAD_LAST = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DEAD  = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t          state_q;
  logic            target_dir;
  logic [PW_W-1:0] target_duty;
  logic [TW-1:0]   tick_cnt;
  logic [DW-1:0]   dead_cnt;
  logic [3:0]      pins;

  logic            tick;
  logic            reversing;
  logic [PW_W-1:0] eff_target;
  logic [PW_W-1:0] ramped;
  logic [PW_W-1:0] duty_sat;

  // Pin order is {in1_a, in2_a, in1_b, in2_b}; motor B is wired mirrored to motor A.
  function automatic logic [3:0] dir_pins(input logic dir);
    return {dir, ~dir, ~dir, dir};
  endfunction

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    tick       = (tick_cnt == TICK_LAST);
    reversing  = (target_dir != cur_dir);
    eff_target = reversing ? '0 : target_duty;
    duty_sat   = (cmd_duty > FULL) ? FULL : cmd_duty;
    ramped     = pulse_width;
    if (pulse_width < eff_target)
      ramped = (eff_target - pulse_width > STEP) ? pulse_width + STEP : eff_target;
    else if (pulse_width > eff_target)
      ramped = (pulse_width - eff_target > STEP) ? pulse_width - STEP : eff_target;
  end

  assign {in1_a, in2_a, in1_b, in2_b} = pins;
  assign cmd_ready = (state_q != FAULT);
  assign state     = state_q;
  assign busy      = (state_q == DEAD) || ((state_q == RUN) && (pulse_width != eff_target));

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pulse_width <= '0;
      cur_dir     <= 1'b1;
      target_dir  <= 1'b1;
      target_duty <= '0;
      tick_cnt    <= '0;
      dead_cnt    <= '0;
      pins        <= dir_pins(1'b1);
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (oc_fault) begin
        state_q     <= FAULT;
        pulse_width <= '0;
        target_duty <= '0;
        pins        <= '0;
      end else begin
        case (state_q)
          RUN: begin
            if (reversing && pulse_width == '0) begin
              state_q  <= DEAD;
              dead_cnt <= '0;
              pins     <= '0;
            end else if (tick) begin
              pulse_width <= ramped;
            end
            if (cmd_valid) begin
              target_dir  <= cmd_dir;
              target_duty <= duty_sat;
            end
          end
          DEAD: begin
            pulse_width <= '0;
            dead_cnt    <= dead_cnt + 1'b1;
            // The flip uses the target registered before this edge; a command landing
            // on the same edge is seen by RUN on the next cycle.
            if (dead_cnt == DEAD_LAST) begin
              cur_dir <= target_dir;
              state_q <= RUN;
              pins    <= dir_pins(target_dir);
            end
            if (cmd_valid) begin
              target_dir  <= cmd_dir;
              target_duty <= duty_sat;
            end
          end
          FAULT: begin
            pulse_width <= '0;
            if (fault_clr) begin
              state_q     <= RUN;
              target_duty <= '0;
              pins        <= dir_pins(cur_dir);
            end
          end
          default: begin
            state_q     <= FAULT;
            pulse_width <= '0;
            pins        <= '0;
          end
        endcase
      end
    end
  end

endmodule
